// File: rtl/spec_accumulator_pkg.sv
// Shared types and helpers for the multi-pulse power-spectrum accumulator.
package spec_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    READY  = 2'd2,
    UPLOAD = 2'd3
  } state_e;

  localparam int unsigned IN_W_DEF  = 50;
  localparam int unsigned ACC_W_DEF = 64;
  localparam int unsigned MAX_W     = 128;

  // Operands are zero-extended to MAX_W, so the raw sum cannot wrap for w < MAX_W.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] acc,
                                                input logic [MAX_W-1:0] x,
                                                input int unsigned      w);
    logic [MAX_W-1:0] lim;
    logic [MAX_W-1:0] sum;
    lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    sum = acc + x;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/spec_accumulator_if.sv
// Capture/upload signal bundle between the spectrum stage, accumulator and upload switcher.
interface spec_accumulator_if
  import spec_accumulator_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
);
  logic              acc_en_i;
  logic [15:0]       nacc_i;
  logic [IN_W-1:0]   spec_i;
  logic              spec_valid_i;
  logic              upload_trig_i;
  logic [ACC_W-1:0]  data_o;
  logic              valid_o;
  logic              ready_o;
  logic              busy_o;
  logic              drop_o;

  modport master (
    output acc_en_i, nacc_i, spec_i, spec_valid_i, upload_trig_i,
    input  data_o, valid_o, ready_o, busy_o, drop_o
  );

  modport slave (
    input  acc_en_i, nacc_i, spec_i, spec_valid_i, upload_trig_i,
    output data_o, valid_o, ready_o, busy_o, drop_o
  );
endinterface

// File: rtl/spec_acc_ram.sv
// Simple dual-port DEPTH x W RAM with registered read; contents are never reset.
module spec_acc_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned W     = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/spec_accumulator.sv
// Sums per-pulse power spectra bin by bin into RAM over a programmed pulse count,
// then streams the accumulated spectrum out on an upload trigger.
module spec_accumulator
  import spec_accumulator_pkg::*;
#(
  parameter int unsigned NFFT  = 1024,
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  spec_accumulator_if.slave bus
);
  localparam int unsigned   AW       = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_BIN = AW'(NFFT - 1);

  state_e            state_q;
  logic              acc_en_q;
  logic [15:0]       nacc_q, pls_cnt_q;
  logic [AW-1:0]     bin_cnt_q, up_cnt_q;
  logic              s1_v_q, s1_first_q, s1_last_q;
  logic [AW-1:0]     s1_addr_q;
  logic [IN_W-1:0]   s1_spec_q;
  logic              s2_v_q, s2_last_q;
  logic [AW-1:0]     s2_addr_q;
  logic [ACC_W-1:0]  s2_data_q;
  logic              rd_v_q, valid_q, ready_q, busy_q, drop_q;
  logic [ACC_W-1:0]  data_q, ram_rdata;

  logic              rise, fall, done, abort, beat_ok, trig_ok, rd_en;
  logic [AW-1:0]     rd_addr;
  logic [15:0]       nacc_d;
  logic [ACC_W-1:0]  sum_d;

  always_comb begin
    rise    = bus.acc_en_i & ~acc_en_q;
    fall    = ~bus.acc_en_i & acc_en_q;
    done    = (pls_cnt_q == nacc_q);
    abort   = (state_q == ACCUM) && fall && !done;
    // Once every beat is in, the pipeline drains in ACCUM and further beats are refused.
    beat_ok = (state_q == ACCUM) && bus.spec_valid_i && !done && !fall;
    trig_ok = (state_q == READY) && bus.upload_trig_i;
    rd_en   = beat_ok || trig_ok || (state_q == UPLOAD);
    rd_addr = '0;
    if (beat_ok)                rd_addr = bin_cnt_q;
    else if (state_q == UPLOAD) rd_addr = up_cnt_q;
    nacc_d  = (bus.nacc_i == 16'd0) ? 16'd1 : bus.nacc_i;
    sum_d   = s1_first_q ? ACC_W'(s1_spec_q)
                         : ACC_W'(sat_add(MAX_W'(ram_rdata), MAX_W'(s1_spec_q), ACC_W));
  end

  spec_acc_ram #(.DEPTH(NFFT), .W(ACC_W)) u_ram (
    .clk_i  (clk_i),
    .we_i   (s2_v_q),
    .waddr_i(s2_addr_q),
    .wdata_i(s2_data_q),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_en_q  <= 1'b0;
      nacc_q    <= '0;
      pls_cnt_q <= '0;
      bin_cnt_q <= '0;
      up_cnt_q  <= '0;
      s1_v_q    <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_addr_q <= '0;
      s1_spec_q <= '0;
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
      rd_v_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      acc_en_q   <= bus.acc_en_i;
      drop_q     <= bus.spec_valid_i && !beat_ok;
      busy_q     <= (state_q == ACCUM) || (state_q == UPLOAD);
      rd_v_q     <= trig_ok || (state_q == UPLOAD);
      valid_q    <= rd_v_q;
      data_q     <= rd_v_q ? ram_rdata : '0;

      s1_v_q     <= beat_ok;
      s1_addr_q  <= bin_cnt_q;
      s1_spec_q  <= bus.spec_i;
      s1_first_q <= (pls_cnt_q == 16'd0);
      s1_last_q  <= (bin_cnt_q == LAST_BIN) && (pls_cnt_q + 16'd1 == nacc_q);
      s2_v_q     <= s1_v_q;
      s2_last_q  <= s1_last_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= sum_d;

      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (rise) begin
            state_q   <= ACCUM;
            nacc_q    <= nacc_d;
            bin_cnt_q <= '0;
            pls_cnt_q <= '0;
          end
        end
        ACCUM: begin
          ready_q <= 1'b0;
          if (abort) begin
            state_q <= IDLE;
          end else begin
            if (beat_ok) begin
              bin_cnt_q <= bin_cnt_q + AW'(1);
              if (bin_cnt_q == LAST_BIN) pls_cnt_q <= pls_cnt_q + 16'd1;
            end
            // READY is entered together with the final bin's write.
            if (s2_v_q && s2_last_q) begin
              state_q <= READY;
              ready_q <= 1'b1;
            end
          end
        end
        READY: begin
          ready_q <= !trig_ok;
          if (trig_ok) begin
            state_q  <= UPLOAD;
            up_cnt_q <= AW'(1);
          end
        end
        UPLOAD: begin
          ready_q  <= 1'b0;
          up_cnt_q <= up_cnt_q + AW'(1);
          if (up_cnt_q == LAST_BIN) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
  assign bus.drop_o  = drop_q;
endmodule

// File: tb/tb_spec_accumulator.sv
// Randomized self-checking bench for spec_accumulator against a per-bin sum model.
module tb_spec_accumulator;
  import spec_accumulator_pkg::*;

  localparam int unsigned NFFT  = 8;
  localparam int unsigned IN_W  = 50;
  localparam int unsigned ACC_W = 64;
  localparam int unsigned SAT_W = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spec_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();
  spec_accumulator_if #(.IN_W(IN_W), .ACC_W(SAT_W)) bs ();

  spec_accumulator #(.NFFT(NFFT), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  spec_accumulator #(.NFFT(NFFT), .IN_W(IN_W), .ACC_W(SAT_W)) dut_sat (
    .clk_i(clk), .rst_i(rst), .bus(bs)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [127:0] msum [NFFT];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] sat_ref(input logic [127:0] s, input int unsigned w);
    logic [127:0] lim;
    lim = (128'(1) << w) - 128'(1);
    return (s > lim) ? lim : s;
  endfunction

  function automatic logic [IN_W-1:0] pat_val(input int unsigned pat, input int unsigned p,
                                              input int unsigned b);
    case (pat)
      0:       return IN_W'(b + 1);
      1:       return IN_W'((p + 1) * (b + 1));
      default: return IN_W'({$urandom(), $urandom()});
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.acc_en_i = 1'b0; bus.nacc_i = '0; bus.spec_i = '0;
    bus.spec_valid_i = 1'b0; bus.upload_trig_i = 1'b0;
    bs.acc_en_i = 1'b0; bs.nacc_i = '0; bs.spec_i = '0;
    bs.spec_valid_i = 1'b0; bs.upload_trig_i = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.data_o !== '0) $display("FAIL reset_data: got %0h want 0", bus.data_o); else n_pass++;
    n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid_o); else n_pass++;
    n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.drop_o !== 1'b0) $display("FAIL reset_drop: got %b want 0", bus.drop_o); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  // Drives one accumulation group and checks ready/busy timing after the final beat.
  task automatic accumulate(input int unsigned nacc, input int unsigned pat,
                            input int unsigned max_gap, input bit trig_mid);
    int unsigned n_eff;
    logic [IN_W-1:0] v;
    logic bad;
    n_eff = (nacc == 0) ? 1 : nacc;
    bus.acc_en_i = 1'b0;
    step();
    bus.nacc_i = 16'(nacc);
    bus.acc_en_i = 1'b1;
    step();
    bus.nacc_i = 16'($urandom_range(1, 9));
    bad = 1'b0;
    for (int p = 0; p < int'(n_eff); p++) begin
      for (int b = 0; b < int'(NFFT); b++) begin
        repeat ($urandom_range(0, max_gap)) step();
        v = pat_val(pat, p, b);
        msum[b] = (p == 0) ? 128'(v) : msum[b] + 128'(v);
        bus.spec_i = v;
        bus.spec_valid_i = 1'b1;
        bus.upload_trig_i = trig_mid && (p == 0) && (b == 2);
        step();
        bus.spec_valid_i = 1'b0;
        bus.upload_trig_i = 1'b0;
        if (bus.drop_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0) bad = 1'b1;
      end
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL accum_quiet: got drop/valid/ready activity %b want none", bad); else n_pass++;
    step();
    n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL ready_early: got %b want 0", bus.ready_o); else n_pass++;
    step();
    n_checks++; if (bus.ready_o !== 1'b1) $display("FAIL ready_late: got %b want 1", bus.ready_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL busy_lag: got %b want 1", bus.busy_o); else n_pass++;
    step();
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL busy_ready: got %b want 0", bus.busy_o); else n_pass++;
    bus.acc_en_i = 1'b0;
  endtask

  task automatic upload(input bit inject);
    logic beat;
    logic [ACC_W-1:0] expv;
    bus.upload_trig_i = 1'b1;
    step();
    bus.upload_trig_i = 1'b0;
    n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL upload_latency: got valid %b want 0", bus.valid_o); else n_pass++;
    for (int i = 0; i < int'(NFFT); i++) begin
      beat = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.spec_valid_i = beat;
      bus.spec_i = IN_W'({$urandom(), $urandom()});
      step();
      bus.spec_valid_i = 1'b0;
      expv = ACC_W'(sat_ref(msum[i], ACC_W));
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== expv)
        $display("FAIL upload_word%0d: got valid %b data %0h want valid 1 data %0h", i, bus.valid_o, bus.data_o, expv);
      else n_pass++;
      if (inject) begin
        n_checks++; if (bus.drop_o !== beat) $display("FAIL upload_drop%0d: got %b want %b", i, bus.drop_o, beat); else n_pass++;
      end
    end
    step();
    n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL upload_len: got valid %b want 0", bus.valid_o); else n_pass++;
    n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL upload_ready: got %b want 0", bus.ready_o); else n_pass++;
  endtask

  task automatic test_basic();
    accumulate(1, 0, 0, 1'b0);
    upload(1'b0);
  endtask

  task automatic test_multi_gaps();
    accumulate(3, 1, 3, 1'b0);
    upload(1'b0);
  endtask

  task automatic test_random();
    accumulate(0, 2, 2, 1'b0);
    upload(1'b0);
    accumulate($urandom_range(2, 5), 2, 3, 1'b0);
    upload(1'b0);
  endtask

  task automatic test_trig_in_accum();
    accumulate(2, 2, 1, 1'b1);
    upload(1'b0);
  endtask

  task automatic test_drops();
    logic beat;
    accumulate(2, 2, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.spec_valid_i = beat;
      bus.spec_i = IN_W'({$urandom(), $urandom()});
      step();
      bus.spec_valid_i = 1'b0;
      n_checks++; if (bus.drop_o !== beat) $display("FAIL ready_drop%0d: got %b want %b", i, bus.drop_o, beat); else n_pass++;
    end
    n_checks++; if (bus.ready_o !== 1'b1) $display("FAIL ready_hold: got %b want 1", bus.ready_o); else n_pass++;
    upload(1'b1);
  endtask

  task automatic test_abort();
    logic seen;
    bus.acc_en_i = 1'b0;
    step();
    bus.nacc_i = 16'd2;
    bus.acc_en_i = 1'b1;
    step();
    for (int i = 0; i < int'(NFFT + NFFT / 2); i++) begin
      bus.spec_i = IN_W'({$urandom(), $urandom()});
      bus.spec_valid_i = 1'b1;
      step();
    end
    bus.spec_valid_i = 1'b0;
    bus.acc_en_i = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      seen = seen | bus.ready_o;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_ready: got %b want 0", seen); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy_o); else n_pass++;
    bus.upload_trig_i = 1'b1;
    step();
    bus.upload_trig_i = 1'b0;
    seen = 1'b0;
    repeat (NFFT + 4) begin
      seen = seen | bus.valid_o;
      step();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_trig: got valid %b want 0", seen); else n_pass++;
    bus.spec_valid_i = 1'b1;
    step();
    bus.spec_valid_i = 1'b0;
    n_checks++; if (bus.drop_o !== 1'b1) $display("FAIL idle_drop: got %b want 1", bus.drop_o); else n_pass++;
    step();
    n_checks++; if (bus.drop_o !== 1'b0) $display("FAIL idle_drop_pulse: got %b want 0", bus.drop_o); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [127:0] ssum [NFFT];
    logic [IN_W-1:0] v;
    logic [SAT_W-1:0] expv;
    logic got;
    int unsigned k;
    bs.nacc_i = 16'd2;
    bs.acc_en_i = 1'b1;
    step();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < int'(NFFT); b++) begin
        if (b < 6)       v = IN_W'(1) << 49;
        else if (b == 6) v = (IN_W'(1) << 49) - IN_W'(1);
        else             v = IN_W'(1) << 48;
        ssum[b] = (p == 0) ? 128'(v) : ssum[b] + 128'(v);
        bs.spec_i = v;
        bs.spec_valid_i = 1'b1;
        step();
      end
    end
    bs.spec_valid_i = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      got = bs.ready_o;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL sat_ready: got %b want 1 within 20 cycles", got); else n_pass++;
    bs.acc_en_i = 1'b0;
    bs.upload_trig_i = 1'b1;
    step();
    bs.upload_trig_i = 1'b0;
    k = 0;
    for (int c = 0; c < int'(NFFT) + 10 && k < NFFT; c++) begin
      step();
      if (bs.valid_o === 1'b1) begin
        expv = SAT_W'(sat_ref(ssum[k], SAT_W));
        n_checks++;
        if (bs.data_o !== expv) $display("FAIL sat_word%0d: got %0h want %0h", k, bs.data_o, expv);
        else n_pass++;
        k++;
      end
    end
    n_checks++; if (k !== NFFT) $display("FAIL sat_count: got %0d words want %0d", k, NFFT); else n_pass++;
  endtask

  task automatic test_reset_mid_upload();
    logic [ACC_W-1:0] expv;
    accumulate(2, 2, 2, 1'b0);
    bus.upload_trig_i = 1'b1;
    step();
    bus.upload_trig_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expv = ACC_W'(sat_ref(msum[i], ACC_W));
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== expv)
        $display("FAIL pre_reset_word%0d: got valid %b data %0h want valid 1 data %0h", i, bus.valid_o, bus.data_o, expv);
      else n_pass++;
    end
    rst = 1'b1;
    step();
    n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.valid_o); else n_pass++;
    n_checks++;
    if ({bus.data_o, bus.ready_o, bus.busy_o, bus.drop_o} !== '0)
      $display("FAIL midrst_outputs: got data %0h ready %b busy %b drop %b want all 0",
               bus.data_o, bus.ready_o, bus.busy_o, bus.drop_o);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    accumulate(1, 2, 1, 1'b0);
    upload(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_gaps();
    test_random();
    test_trig_in_accum();
    test_drops();
    test_abort();
    test_drops();
    test_saturation();
    test_reset_mid_upload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
